// File: rtl/pcie_axi_endpoint_if.sv
// Bus bundle for pcie_axi_endpoint: APB control port plus AXI write channels (AW/W/B).
interface pcie_axi_endpoint_if #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32
);
    // APB
    logic                      psel;
    logic                      penable;
    logic [11:0]               paddr;
    logic                      pwrite;
    logic [31:0]               pwdata;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;
    // AXI write address
    logic                      awvalid;
    logic                      awready;
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    // AXI write data
    logic                      wvalid;
    logic                      wready;
    logic [AXI_ID_WIDTH-1:0]   wid;
    logic [127:0]              wdata;
    logic [15:0]               wstrb;
    logic                      wlast;
    // AXI write response
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wid, wdata, wstrb, wlast,
        input  wready,
        output bready,
        input  bvalid, bid, bresp
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wid, wdata, wstrb, wlast,
        output wready,
        input  bready,
        output bvalid, bid, bresp
    );
endinterface

// File: rtl/pcie_axi_endpoint.sv
// PCIe write-ingress endpoint: AXI write bursts into a 128-bit staging buffer, APB control/status.
// Optional build macro PCIE_ADDR_CHECK_EN: reject unaligned or out-of-range bursts with SLVERR.
module pcie_axi_endpoint #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    pcie_axi_endpoint_if.slave bus
);
    localparam int unsigned IDXW = $clog2(MEM_DEPTH);
`ifdef PCIE_ADDR_CHECK_EN
    localparam int unsigned AEW  = AXI_ADDR_WIDTH + 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;

    state_e                    state_q, state_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                beat_q, beat_d;
    logic                      err_q, err_d;
    logic                      sup_q, sup_d;

    logic                      ctrl_en_q;
    logic                      sticky_err_q;
    logic [31:0]               wr_cnt_q;
    logic [31:0]               last_addr_q;
    logic [IDXW+1:0]           mem_idx_q;
    logic [127:0]              mem_q [MEM_DEPTH];

    logic aw_hs, w_hs, b_hs, last_beat, aw_bad;
    logic apb_acc, apb_wr, mapped;
    logic [IDXW-1:0] wr_idx;
    logic [127:0]    rd_entry;
    logic            unused_c;

    assign aw_hs     = bus.awvalid && awready_q;
    assign w_hs      = bus.wvalid && wready_q;
    assign b_hs      = bvalid_q && bus.bready;
    assign last_beat = (beat_q == len_q);
    assign wr_idx    = IDXW'(addr_q >> 4) + IDXW'(beat_q);
    assign apb_acc   = bus.psel && bus.penable;
    assign apb_wr    = apb_acc && bus.pwrite;

    // Burst-level errors detected at address acceptance; these also block buffer writes.
    always_comb begin
`ifdef PCIE_ADDR_CHECK_EN
        logic [AEW-1:0] aw_end;
        aw_end = AEW'(bus.awaddr) + AEW'({bus.awlen, 4'h0}) + AEW'(16);
`endif
        aw_bad = (bus.awsize != 3'd4) || (bus.awburst != 2'b01) || !ctrl_en_q;
`ifdef PCIE_ADDR_CHECK_EN
        if ((bus.awaddr[3:0] != 4'h0) || (aw_end > AEW'(16 * MEM_DEPTH))) begin
            aw_bad = 1'b1;
        end
`endif
    end

    // FSM state and burst context registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            sup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            sup_q     <= sup_d;
        end
    end

    // Next-state and burst context update.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        sup_d   = sup_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs) begin
                    state_d = S_DATA;
                    id_d    = bus.awid;
                    addr_d  = bus.awaddr;
                    len_d   = bus.awlen;
                    beat_d  = 8'd0;
                    err_d   = aw_bad;
                    sup_d   = aw_bad;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (bus.wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they register alongside it.
    always_comb begin
        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_DATA);
        bvalid_d  = (state_d == S_RESP);
    end

    // Byte-strobed buffer write; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_hs && !sup_q) begin
            for (int i = 0; i < 16; i++) begin
                if (bus.wstrb[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // APB-visible control, status and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_en_q    <= 1'b1;
            sticky_err_q <= 1'b0;
            wr_cnt_q     <= '0;
            last_addr_q  <= '0;
            mem_idx_q    <= '0;
        end else begin
            if (apb_wr && bus.paddr == 12'h000) begin
                ctrl_en_q <= bus.pwdata[0];
            end
            if (apb_wr && bus.paddr == 12'h010) begin
                mem_idx_q <= bus.pwdata[IDXW+1:0];
            end
            if (b_hs && err_q) begin
                sticky_err_q <= 1'b1;
            end else if (apb_wr && bus.paddr == 12'h004 && bus.pwdata[1]) begin
                sticky_err_q <= 1'b0;
            end
            if (b_hs && !err_q) begin
                wr_cnt_q    <= wr_cnt_q + 32'd1;
                last_addr_q <= 32'(addr_q);
            end
        end
    end

    assign rd_entry = mem_q[mem_idx_q[IDXW+1:2]];

    // Zero-wait APB read mux and address decode.
    always_comb begin
        bus.prdata = '0;
        mapped     = 1'b1;
        case (bus.paddr)
            12'h000: bus.prdata = {31'd0, ctrl_en_q};
            12'h004: bus.prdata = {30'd0, sticky_err_q, (state_q != S_IDLE)};
            12'h008: bus.prdata = wr_cnt_q;
            12'h00C: bus.prdata = last_addr_q;
            12'h010: bus.prdata = 32'(mem_idx_q);
            12'h014: bus.prdata = rd_entry[{mem_idx_q[1:0], 5'd0} +: 32];
            default: mapped = 1'b0;
        endcase
        if (!(apb_acc && !bus.pwrite)) begin
            bus.prdata = '0;
        end
    end

    assign bus.pready  = 1'b1;
    assign bus.pslverr = apb_acc && !mapped;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = id_q;
    assign bus.bresp   = {err_q, 1'b0};

    assign unused_c = ^{bus.wid, bus.pwdata, addr_q};
endmodule

// File: tb/tb_pcie_axi_endpoint.sv
// Directed bench for pcie_axi_endpoint.
module tb_pcie_axi_endpoint;
    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_STAT = 12'h004;
    localparam logic [11:0] A_WCNT = 12'h008;
    localparam logic [11:0] A_LADR = 12'h00C;
    localparam logic [11:0] A_MIDX = 12'h010;
    localparam logic [11:0] A_MDAT = 12'h014;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    pcie_axi_endpoint_if #(.AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32)) bus ();

    pcie_axi_endpoint #(.AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .MEM_DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
        @(negedge clk);
        bus.penable = 1'b1;
        @(posedge clk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        @(negedge clk);
        bus.penable = 1'b1;
        #1 d = bus.prdata; e = bus.pslverr;
        @(posedge clk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic read_word(input int entry, input int word, output logic [31:0] d);
        logic e;
        apb_write(A_MIDX, 32'((entry << 2) | word));
        apb_read(A_MDAT, d, e);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = size; bus.awburst = burst;
        while (!bus.awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL aw_timeout got awready=%b want 1", bus.awready); end
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] d, input logic [15:0] s, input logic last);
        int n = 0;
        @(negedge clk);
        bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
        while (!bus.wready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL w_timeout got wready=%b want 1", bus.wready); end
        @(posedge clk);
        #1 bus.wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [3:0] bid, output logic [1:0] bresp);
        int n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL b_timeout got bvalid=%b want 1", bus.bvalid); end
        bid = bus.bid; bresp = bus.bresp;
        bus.bready = 1'b1;
        @(posedge clk);
        #1 bus.bready = 1'b0;
    endtask

    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [127:0] d,
                            input logic [15:0] s, input logic early_last,
                            output logic [3:0] bid, output logic [1:0] bresp);
        fork
            send_aw(id, addr, len, size, burst);
            begin
                for (int b = 0; b <= int'(len); b++) begin
                    send_w(d, s, early_last ? (b == 0) : (b == int'(len)));
                end
            end
        join
        wait_b(bid, bresp);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.awready !== 1'b0 || bus.bvalid !== 1'b0 || bus.pready !== 1'b1) begin
            bad++; $display("FAIL reset_outs got awready=%b bvalid=%b pready=%b want 0 0 1", bus.awready, bus.bvalid, bus.pready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (250) @(posedge clk);
        @(negedge clk);
        total++; if ({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid} !== {3'b100, 2'b00, 4'h0}) begin
            bad++; $display("FAIL idle_outs got aw=%b w=%b b=%b resp=%b id=%h want 1 0 0 00 0", bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid);
        end
        apb_read(A_WCNT, d, e);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_wrcnt got %h want 0", d); end
        apb_read(A_CTRL, d, e);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL reset_ctrl got %h want 1", d); end
        apb_read(A_STAT, d, e);
        total++; if (d !== 32'd0 || e !== 1'b0) begin bad++; $display("FAIL reset_status got %h err=%b want 0 0", d, e); end
    endtask

    task automatic test_burst();
        logic [3:0] bid; logic [1:0] br; logic [31:0] d; logic e;
        do_burst(4'h0, 32'h0, 8'd1, 3'd4, 2'b01, {4{32'h01234567}}, 16'hFFFF, 1'b0, bid, br);
        total++; if (bid !== 4'h0 || br !== 2'b00) begin bad++; $display("FAIL burst0_b got id=%h resp=%b want 0 00", bid, br); end
        for (int i = 0; i < 8; i++) begin
            read_word(i / 4, i % 4, d);
            total++; if (d !== 32'h01234567) begin bad++; $display("FAIL burst0_mem idx=%0d got %h want 01234567", i, d); end
        end
        apb_read(A_WCNT, d, e);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL burst0_wrcnt got %h want 1", d); end
    endtask

    task automatic test_burst_offset();
        logic [3:0] bid; logic [1:0] br; logic [31:0] d; logic e;
        do_burst(4'h5, 32'h20, 8'd1, 3'd4, 2'b01, {4{32'h01234567}}, 16'hFFFF, 1'b0, bid, br);
        total++; if (bid !== 4'h5 || br !== 2'b00) begin bad++; $display("FAIL burst20_b got id=%h resp=%b want 5 00", bid, br); end
        read_word(2, 0, d);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL burst20_e2 got %h want 01234567", d); end
        read_word(3, 3, d);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL burst20_e3 got %h want 01234567", d); end
        apb_read(A_WCNT, d, e);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL burst20_wrcnt got %h want 2", d); end
        apb_read(A_LADR, d, e);
        total++; if (d !== 32'h20) begin bad++; $display("FAIL burst20_lastaddr got %h want 20", d); end
    endtask

    task automatic test_strobe();
        logic [3:0] bid; logic [1:0] br; logic [31:0] d;
        do_burst(4'h1, 32'h40, 8'd0, 3'd4, 2'b01, 128'd0, 16'hFFFF, 1'b0, bid, br);
        do_burst(4'h2, 32'h40, 8'd0, 3'd4, 2'b01, {128{1'b1}}, 16'h000F, 1'b0, bid, br);
        total++; if (br !== 2'b00) begin bad++; $display("FAIL strobe_b got resp=%b want 00", br); end
        for (int w = 0; w < 4; w++) begin
            read_word(4, w, d);
            total++; if (d !== ((w == 0) ? 32'hFFFFFFFF : 32'h0)) begin
                bad++; $display("FAIL strobe_word%0d got %h want %h", w, d, (w == 0) ? 32'hFFFFFFFF : 32'h0);
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0] bid; logic [1:0] br; logic [31:0] d; logic e;
        do_burst(4'h3, 32'h0, 8'd0, 3'd4, 2'b00, {4{32'hDEADBEEF}}, 16'hFFFF, 1'b0, bid, br);
        total++; if (bid !== 4'h3 || br !== 2'b10) begin bad++; $display("FAIL err_burst_b got id=%h resp=%b want 3 10", bid, br); end
        read_word(0, 0, d);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL err_burst_mem got %h want 01234567", d); end
        apb_read(A_STAT, d, e);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL err_burst_status got %h want 2", d); end
        apb_write(A_STAT, 32'h2);
        apb_read(A_STAT, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL err_w1c got %h want 0", d); end

        do_burst(4'h4, 32'h10, 8'd0, 3'd3, 2'b01, {4{32'hDEADBEEF}}, 16'hFFFF, 1'b0, bid, br);
        total++; if (br !== 2'b10) begin bad++; $display("FAIL err_size_b got resp=%b want 10", br); end
        read_word(1, 2, d);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL err_size_mem got %h want 01234567", d); end
        apb_write(A_STAT, 32'h2);

        apb_write(A_CTRL, 32'h0);
        do_burst(4'h6, 32'h20, 8'd0, 3'd4, 2'b01, {4{32'hDEADBEEF}}, 16'hFFFF, 1'b0, bid, br);
        total++; if (br !== 2'b10) begin bad++; $display("FAIL err_dis_b got resp=%b want 10", br); end
        read_word(2, 1, d);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL err_dis_mem got %h want 01234567", d); end
        apb_write(A_CTRL, 32'h1);
        apb_write(A_STAT, 32'h2);

        do_burst(4'h7, 32'h60, 8'd1, 3'd4, 2'b01, {4{32'h5A5A5A5A}}, 16'hFFFF, 1'b1, bid, br);
        total++; if (br !== 2'b10) begin bad++; $display("FAIL err_wlast_b got resp=%b want 10", br); end
        read_word(7, 0, d);
        total++; if (d !== 32'h5A5A5A5A) begin bad++; $display("FAIL err_wlast_mem got %h want 5a5a5a5a", d); end
        apb_read(A_WCNT, d, e);
        total++; if (d !== 32'd4) begin bad++; $display("FAIL err_wrcnt got %h want 4", d); end
        apb_write(A_STAT, 32'h2);
    endtask

    task automatic test_bhold();
        logic [31:0] d; logic e;
        fork
            send_aw(4'h9, 32'h80, 8'd0, 3'd4, 2'b01);
            send_w({4{32'h11112222}}, 16'hFFFF, 1'b1);
        join
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            total++; if ({bus.bvalid, bus.bid, bus.bresp, bus.awready} !== {1'b1, 4'h9, 2'b00, 1'b0}) begin
                bad++; $display("FAIL bhold_c%0d got bv=%b id=%h resp=%b awr=%b want 1 9 00 0", c, bus.bvalid, bus.bid, bus.bresp, bus.awready);
            end
            @(negedge clk);
        end
        apb_read(A_STAT, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL bhold_busy got %h want 1", d); end
        bus.bready = 1'b1;
        @(posedge clk);
        #1 bus.bready = 1'b0;
        total++; if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
            bad++; $display("FAIL bhold_release got awr=%b bv=%b want 1 0", bus.awready, bus.bvalid);
        end
        apb_read(A_LADR, d, e);
        total++; if (d !== 32'h80) begin bad++; $display("FAIL bhold_lastaddr got %h want 80", d); end
    endtask

    task automatic test_early_w();
        logic [3:0] bid; logic [1:0] br; logic [31:0] d; logic e;
        @(negedge clk);
        bus.wvalid = 1'b1; bus.wdata = {32'hCAFEF00D, 96'd0}; bus.wstrb = 16'hFFFF; bus.wlast = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL early_w_stall got wready=%b want 0", bus.wready); end
        fork
            send_aw(4'hA, 32'h90, 8'd0, 3'd4, 2'b01);
            send_w({32'hCAFEF00D, 96'd0}, 16'hFFFF, 1'b1);
        join
        wait_b(bid, br);
        total++; if (bid !== 4'hA || br !== 2'b00) begin bad++; $display("FAIL early_w_b got id=%h resp=%b want a 00", bid, br); end
        read_word(9, 3, d);
        total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL early_w_mem got %h want cafef00d", d); end
        apb_read(A_WCNT, d, e);
        total++; if (d !== 32'd6) begin bad++; $display("FAIL early_w_wrcnt got %h want 6", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic e;
        apb_read(12'h018, d, e);
        total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL unmapped_rd got %h err=%b want 0 1", d, e); end
        apb_write(12'h018, 32'hFFFFFFFF);
        apb_read(A_CTRL, d, e);
        total++; if (d !== 32'h1 || e !== 1'b0) begin bad++; $display("FAIL unmapped_wr_ctrl got %h err=%b want 1 0", d, e); end
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0;
        bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b0;
        test_reset();
        test_burst();
        test_burst_offset();
        test_strobe();
        test_errors();
        test_bhold();
        test_early_w();
        test_unmapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcie_axi_endpoint.md
Name: pcie_axi_endpoint

Overview:
- Write-ingress endpoint of the PCIe block. Accepts AXI write bursts (AW/W), stores the payload in an internal buffer that stages memory-write TLP data, and returns a B response.
- An APB slave exposes control, status and counters, plus a read window into the buffer.
- AR/R read channels are handled by a separate block and are not part of this one.

Parameters:
AXI_ID_WIDTH, 4, AXI ID width
AXI_ADDR_WIDTH, 32, AXI address width
MEM_DEPTH, 64, buffer entries of 128 bits (power of two)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
paddr  in  12  APB byte address
pwrite  in  1  APB write
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
awvalid  in  1  AW valid
awready  out  1  AW ready
awid  in  AXI_ID_WIDTH  AW ID
awaddr  in  AXI_ADDR_WIDTH  AW byte address
awlen  in  8  beats minus 1
awsize  in  3  beat size code, 4 = 16 B
awburst  in  2  burst type, 01 = INCR
wvalid  in  1  W valid
wready  out  1  W ready
wid  in  AXI_ID_WIDTH  W ID (ignored)
wdata  in  128  W data
wstrb  in  16  byte strobes
wlast  in  1  last beat
bvalid  out  1  B valid
bready  in  1  B ready
bid  out  AXI_ID_WIDTH  B ID (= captured awid)
bresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset (rst_n low at a clk edge): every output 0 except pready; FSM in IDLE; all registers at reset values. Buffer contents are not reset. pready is constant 1 (zero-wait APB).
- FSM has three states: IDLE, DATA, RESP.
  - IDLE: awready=1. On AW handshake, capture id/addr/len/size/burst, clear beat counter, go to DATA. awready is 0 outside IDLE (one burst outstanding).
  - DATA: wready=1. Each W handshake is one beat.
    - Buffer index = ((awaddr>>4) + beat) mod MEM_DEPTH.
    - Byte i of the entry is written only where wstrb[i]=1.
    - After beat number awlen, go to RESP.
  - RESP: bvalid=1 with bid = captured awid. On bvalid&&bready, return to IDLE. bvalid/bid/bresp hold stable until the handshake.
- W before AW: wready stays 0 in IDLE, so early W beats stall until AW is accepted.
- Error (bresp=10) if any of: awsize!=4, awburst!=01, CTRL.enable=0, or wlast mismatch.
  - Size, burst and enable errors suppress all buffer writes for that burst.
  - wlast mismatch means wlast=1 before the final beat, or wlast=0 on beat awlen. It flags the error only; the beat count still governs burst length and data is written.
- Error sets STATUS.err (sticky).
- OKAY bursts increment WR_CNT (32-bit, wraps) and load LAST_ADDR with the captured awaddr at the B handshake.
- APB access phase is psel&&penable. Reads return registered data the same cycle. Unmapped addresses set pslverr=1; writes to them are ignored and reads return 0.
- APB register map:
  - 0x00 CTRL: bit0 enable, reset 1; RW.
  - 0x04 STATUS: bit0 busy (FSM != IDLE), RO; bit1 err, write-1-to-clear.
  - 0x08 WR_CNT: RO.
  - 0x0C LAST_ADDR: RO.
  - 0x10 MEM_IDX: RW. Bits [1:0] select the 32-bit word, bits [7:2] the entry.
  - 0x14 MEM_DATA: RO, returns the word selected by MEM_IDX.
- Simultaneous events: an error set and an APB W1C in the same cycle leave err=1. An APB write to CTRL during a burst takes effect at the next AW handshake.

Optional Feature:
- Macro PCIE_ADDR_CHECK_EN.
- Defined: SLVERR with no buffer writes if awaddr is not 16-byte aligned, or if the burst end (awaddr + 16*(awlen+1)) exceeds 16*MEM_DEPTH.
- Undefined: low address bits are ignored and the buffer index wraps modulo MEM_DEPTH.

Test Plan:
- Reset low 3 cycles, then 250 idle cycles -> awready=1, wready=0, bvalid=0, WR_CNT=0, CTRL=1.
- AW(id 0, addr 0x0, len 1, size 4, INCR) forked with two W beats {4{32'h01234567}}, strb FFFF, wlast 0 then 1 -> bid=0, bresp=00. MEM_IDX 0x00..0x07 read 0x01234567; WR_CNT=1.
- Same burst at addr 0x20 -> entries 2,3 hold 0x01234567; WR_CNT=2; LAST_ADDR=0x20.
- Single beat to entry 4 with strb 000F, data 0xFFFF..FF, over a prior 0 -> word0=0xFFFFFFFF, words1-3=0.
- Burst with awburst=00 or awsize=3 -> bresp=10, buffer unchanged, STATUS=0x2. APB write 0x2 to 0x04 -> STATUS=0.
- bready held low 5 cycles -> bvalid, bid and bresp stable, awready=0. B handshake -> IDLE and awready=1 next cycle.
